sq_wr_responder: RTL and testbench
==================================

SQ_WR_RESPONDER -- requirements
Module: sq_wr_responder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 512, stream data width in bits (multiple of 32).
REQ-002 SHALL have parameter LEN_BITS, default 28, request length field width in bytes.
REQ-003 SHALL have parameter TID_BITS, default 6, transaction tag width.
REQ-004 SHALL have port aclk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port sq_valid  in  1  write descriptor valid.
REQ-007 SHALL have port sq_ready  out  1  descriptor accept.
REQ-008 SHALL have port sq_len  in  LEN_BITS  request length in bytes.
REQ-009 SHALL have port sq_tid  in  TID_BITS  request tag.
REQ-010 SHALL have port s_axis_tvalid  in  1  data beat valid.
REQ-011 SHALL have port s_axis_tready  out  1  data beat accept.
REQ-012 SHALL have port s_axis_tdata  in  DATA_BITS  payload.
REQ-013 SHALL have port s_axis_tkeep  in  DATA_BITS/8  byte enables.
REQ-014 SHALL have port s_axis_tlast  in  1  last beat of packet.
REQ-015 SHALL have port cq_valid  out  1  completion valid.
REQ-016 SHALL have port cq_ready  in  1  completion accept.
REQ-017 SHALL have port cq_tid  out  TID_BITS  tag of completed request.
REQ-018 SHALL have port cq_status  out  2  00 OK, 01 EARLY_LAST, 10 NO_LAST, 11 KEEP_ERR.
REQ-019 SHALL have port cq_bytes  out  LEN_BITS  bytes received (popcount of accepted tkeep).
REQ-020 SHALL have port cq_csum  out  32  XOR-fold of all accepted 32-bit tdata words, tkeep-masked.
REQ-021 SHALL have port cmpl_cnt  out  32  completions handed off since reset, wraps at 2^32.

Function
REQ-022 SHALL implement FSM states IDLE, DATA, DRAIN, CMPL.
REQ-023 SHALL assert sq_ready only in IDLE; handshake = sq_valid & sq_ready.
REQ-024 On sq handshake SHALL latch sq_tid, sq_len, expected beats = len[LEN_BITS-1:log2(DATA_BITS/8)] + (|low bits); clear byte count, beat count, csum.
REQ-025 On sq handshake with sq_len=0 SHALL go to CMPL next cycle, status OK, bytes 0, csum 0; no data consumed.
REQ-026 Otherwise SHALL go to DATA next cycle; first beat acceptable at cycle T+1 after handshake at T.
REQ-027 SHALL assert s_axis_tready only in DATA and DRAIN; beat accepted = tvalid & tready; one beat per cycle, no bubbles.
REQ-028 Each accepted beat in DATA SHALL add popcount(tkeep) to byte count, XOR tkeep-masked words into csum, increment beat count.
REQ-029 tlast on beat N < expected SHALL go to CMPL with status EARLY_LAST.
REQ-030 Final expected beat with tlast SHALL go to CMPL; status OK if byte count == sq_len, else KEEP_ERR.
REQ-031 Final expected beat without tlast SHALL go to DRAIN with status NO_LAST; DRAIN discards beats (no count/csum update) until tlast accepted, then CMPL.
REQ-032 SHALL assert cq_valid in CMPL, starting the cycle after the terminating beat (or after zero-length handshake); cq_* stable while cq_valid & !cq_ready.
REQ-033 On cq_valid & cq_ready SHALL increment cmpl_cnt and return to IDLE; sq_ready high the following cycle.
REQ-034 Byte count SHALL saturate at 2^LEN_BITS-1; saturation forces KEEP_ERR if otherwise OK.
REQ-035 SHALL not accept a new descriptor while any request is open (single outstanding).

Reset
REQ-036 While areset high: state IDLE, sq_ready 0, s_axis_tready 0, cq_valid 0, cq_tid/cq_status/cq_bytes/cq_csum 0, cmpl_cnt 0; sq_ready 1 first cycle after release.
REQ-037 Reset mid-request SHALL abandon it with no completion; stale beats after release are not accepted until a new descriptor.

Verification
REQ-038 len=128, tid=5, 2 full beats, tlast on beat 2 -> cq_valid cycle after beat 2, status 00, bytes 128, tid 5, cmpl_cnt 1.
REQ-039 len=100, beat1 keep all, beat2 keep 0x0000000FFFFFFFFF (36 B), tlast -> status 00, bytes 100; keep 32 B instead -> status 11, bytes 96.
REQ-040 len=192, tlast on beat 2 -> status 01, bytes 128, no third beat accepted.
REQ-041 len=64, beat1 no tlast, then 3 beats, tlast on 3rd -> status 10, bytes 64, csum reflects beat1 only.
REQ-042 len=0 -> cq_valid 2 cycles after sq_valid rise, status 00, bytes 0; cq_ready held low 5 cycles -> outputs stable, sq_ready 0.
REQ-043 areset pulsed after 1 of 4 beats -> no completion, cmpl_cnt 0, tready 0 until next descriptor.

Source files
------------

// File: rtl/sq_wr_responder.sv
// Write-request responder: takes one descriptor, consumes its data stream and
// reports a completion with byte count, tkeep-masked XOR checksum and status.
module sq_wr_responder #(
   parameter int unsigned DATA_BITS = 512,
   parameter int unsigned LEN_BITS  = 28,
   parameter int unsigned TID_BITS  = 6
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   sq_valid,
   output logic                   sq_ready,
   input  logic [LEN_BITS-1:0]    sq_len,
   input  logic [TID_BITS-1:0]    sq_tid,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [DATA_BITS-1:0]   s_axis_tdata,
   input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
   input  logic                   s_axis_tlast,
   output logic                   cq_valid,
   input  logic                   cq_ready,
   output logic [TID_BITS-1:0]    cq_tid,
   output logic [1:0]             cq_status,
   output logic [LEN_BITS-1:0]    cq_bytes,
   output logic [31:0]            cq_csum,
   output logic [31:0]            cmpl_cnt
);

   localparam int unsigned BYTES     = DATA_BITS / 8;
   localparam int unsigned WORDS     = DATA_BITS / 32;
   localparam int unsigned LOW       = $clog2(BYTES);
   localparam int unsigned BEAT_BITS = LEN_BITS - LOW + 1;
   localparam int unsigned PC_BITS   = $clog2(BYTES + 1);

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_EARLY    = 2'b01;
   localparam logic [1:0] ST_NO_LAST  = 2'b10;
   localparam logic [1:0] ST_KEEP_ERR = 2'b11;

   typedef enum logic [1:0] {IDLE, DATA, DRAIN, CMPL} state_t;

   state_t                 state_q;
   logic                   sq_ready_q, tready_q, cq_valid_q, sat_q;
   logic [TID_BITS-1:0]    cq_tid_q;
   logic [1:0]             cq_status_q;
   logic [LEN_BITS-1:0]    cq_bytes_q, len_q;
   logic [31:0]            cq_csum_q, cmpl_cnt_q;
   logic [BEAT_BITS-1:0]   beat_q, exp_q;

   logic [PC_BITS-1:0]     pop_d;
   logic [31:0]            csum_d;
   logic [LEN_BITS:0]      sum_d;
   logic [LEN_BITS-1:0]    bytes_d;
   logic                   sat_d;
   logic [BEAT_BITS-1:0]   beat_d, exp_d;
   logic                   beat_hs, last_beat;

   always_comb begin
      pop_d = '0;
      for (int unsigned i = 0; i < BYTES; i++)
         pop_d = pop_d + PC_BITS'(s_axis_tkeep[i]);
      csum_d = cq_csum_q;
      for (int unsigned w = 0; w < WORDS; w++)
         for (int unsigned b = 0; b < 4; b++)
            if (s_axis_tkeep[4*w+b])
               csum_d[8*b +: 8] = csum_d[8*b +: 8] ^ s_axis_tdata[32*w+8*b +: 8];
      // Byte count saturates; the sticky flag keeps a saturated count from passing as OK.
      sum_d     = {1'b0, cq_bytes_q} + (LEN_BITS+1)'(pop_d);
      sat_d     = sat_q | sum_d[LEN_BITS];
      bytes_d   = sum_d[LEN_BITS] ? '1 : sum_d[LEN_BITS-1:0];
      beat_d    = beat_q + BEAT_BITS'(1);
      exp_d     = BEAT_BITS'(sq_len[LEN_BITS-1:LOW]) + BEAT_BITS'(|sq_len[LOW-1:0]);
      beat_hs   = s_axis_tvalid & tready_q;
      last_beat = (beat_d == exp_q);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         sq_ready_q  <= 1'b0;
         tready_q    <= 1'b0;
         cq_valid_q  <= 1'b0;
         sat_q       <= 1'b0;
         cq_tid_q    <= '0;
         cq_status_q <= ST_OK;
         cq_bytes_q  <= '0;
         cq_csum_q   <= '0;
         cmpl_cnt_q  <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         exp_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               sq_ready_q <= 1'b1;
               if (sq_valid && sq_ready_q) begin
                  sq_ready_q  <= 1'b0;
                  cq_tid_q    <= sq_tid;
                  len_q       <= sq_len;
                  exp_q       <= exp_d;
                  beat_q      <= '0;
                  cq_bytes_q  <= '0;
                  cq_csum_q   <= '0;
                  sat_q       <= 1'b0;
                  cq_status_q <= ST_OK;
                  if (sq_len == '0) begin
                     state_q    <= CMPL;
                     cq_valid_q <= 1'b1;
                  end else begin
                     state_q  <= DATA;
                     tready_q <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (beat_hs) begin
                  beat_q     <= beat_d;
                  cq_bytes_q <= bytes_d;
                  cq_csum_q  <= csum_d;
                  sat_q      <= sat_d;
                  if (s_axis_tlast) begin
                     state_q    <= CMPL;
                     tready_q   <= 1'b0;
                     cq_valid_q <= 1'b1;
                     if (!last_beat)
                        cq_status_q <= ST_EARLY;
                     else if (bytes_d == len_q && !sat_d)
                        cq_status_q <= ST_OK;
                     else
                        cq_status_q <= ST_KEEP_ERR;
                  end else if (last_beat) begin
                     state_q     <= DRAIN;
                     cq_status_q <= ST_NO_LAST;
                  end
               end
            end
            DRAIN: begin
               if (beat_hs && s_axis_tlast) begin
                  state_q    <= CMPL;
                  tready_q   <= 1'b0;
                  cq_valid_q <= 1'b1;
               end
            end
            CMPL: begin
               if (cq_valid_q && cq_ready) begin
                  state_q    <= IDLE;
                  cq_valid_q <= 1'b0;
                  sq_ready_q <= 1'b1;
                  cmpl_cnt_q <= cmpl_cnt_q + 32'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sq_ready      = sq_ready_q;
   assign s_axis_tready = tready_q;
   assign cq_valid      = cq_valid_q;
   assign cq_tid        = cq_tid_q;
   assign cq_status     = cq_status_q;
   assign cq_bytes      = cq_bytes_q;
   assign cq_csum       = cq_csum_q;
   assign cmpl_cnt      = cmpl_cnt_q;

endmodule

// File: tb/tb_sq_wr_responder.sv
// Directed bench for sq_wr_responder: default-width instance plus a narrow
// LEN_BITS=8 instance for byte-count saturation.
module tb_sq_wr_responder;

   localparam int unsigned DB = 512;
   localparam int unsigned KB = DB / 8;
   localparam int unsigned LB = 28;
   localparam int unsigned TB = 6;

   logic          clk = 1'b0;
   logic          areset;
   logic          sq_valid, sq_ready, s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic          cq_valid, cq_ready;
   logic [LB-1:0] sq_len, cq_bytes;
   logic [TB-1:0] sq_tid, cq_tid;
   logic [DB-1:0] s_axis_tdata;
   logic [KB-1:0] s_axis_tkeep;
   logic [1:0]    cq_status;
   logic [31:0]   cq_csum, cmpl_cnt;

   logic          s8_sq_valid, s8_sq_ready, s8_tvalid, s8_tready, s8_tlast;
   logic          s8_cq_valid, s8_cq_ready;
   logic [7:0]    s8_sq_len, s8_cq_bytes;
   logic [TB-1:0] s8_sq_tid, s8_cq_tid;
   logic [DB-1:0] s8_tdata;
   logic [KB-1:0] s8_tkeep;
   logic [1:0]    s8_cq_status;
   logic [31:0]   s8_cq_csum, s8_cmpl_cnt;

   int unsigned vec = 0;
   int unsigned err = 0;
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   sq_wr_responder u_dut (
      .aclk(clk), .areset(areset),
      .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_len(sq_len), .sq_tid(sq_tid),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .cq_valid(cq_valid), .cq_ready(cq_ready), .cq_tid(cq_tid), .cq_status(cq_status),
      .cq_bytes(cq_bytes), .cq_csum(cq_csum), .cmpl_cnt(cmpl_cnt)
   );

   sq_wr_responder #(.DATA_BITS(512), .LEN_BITS(8), .TID_BITS(6)) u_dut8 (
      .aclk(clk), .areset(areset),
      .sq_valid(s8_sq_valid), .sq_ready(s8_sq_ready), .sq_len(s8_sq_len), .sq_tid(s8_sq_tid),
      .s_axis_tvalid(s8_tvalid), .s_axis_tready(s8_tready),
      .s_axis_tdata(s8_tdata), .s_axis_tkeep(s8_tkeep), .s_axis_tlast(s8_tlast),
      .cq_valid(s8_cq_valid), .cq_ready(s8_cq_ready), .cq_tid(s8_cq_tid), .cq_status(s8_cq_status),
      .cq_bytes(s8_cq_bytes), .cq_csum(s8_cq_csum), .cmpl_cnt(s8_cmpl_cnt)
   );

   // Called on a falling edge; returns on the falling edge after the handshake edge.
   task automatic send_desc(input logic [LB-1:0] len, input logic [TB-1:0] tid);
      int unsigned n = 0;
      sq_valid = 1'b1; sq_len = len; sq_tid = tid;
      while (!sq_ready && n < 20) begin @(negedge clk); n++; end
      if (!sq_ready) begin
         vec++; err++;
         $display("FAIL sq_handshake_timeout: sq_ready=%0b required 1", sq_ready);
      end
      @(negedge clk);
      sq_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [DB-1:0] d, input logic [KB-1:0] k, input logic last);
      int unsigned n = 0;
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last;
      while (!s_axis_tready && n < 20) begin @(negedge clk); n++; end
      if (!s_axis_tready) begin
         vec++; err++;
         $display("FAIL beat_timeout: s_axis_tready=%0b required 1", s_axis_tready);
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic retire();
      cq_ready = 1'b1;
      @(negedge clk);
      cq_ready = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) @(negedge clk);
      vec++; if (sq_ready !== 1'b0) begin err++; $display("FAIL rst_sq_ready got %b exp 0", sq_ready); end
      vec++; if (s_axis_tready !== 1'b0) begin err++; $display("FAIL rst_tready got %b exp 0", s_axis_tready); end
      vec++; if (cq_valid !== 1'b0) begin err++; $display("FAIL rst_cq_valid got %b exp 0", cq_valid); end
      vec++; if ({cq_tid, cq_status, cq_bytes, cq_csum} !== '0) begin err++;
         $display("FAIL rst_cq_fields got tid=%h st=%b bytes=%h csum=%h exp all 0", cq_tid, cq_status, cq_bytes, cq_csum); end
      vec++; if (cmpl_cnt !== 32'd0) begin err++; $display("FAIL rst_cmpl_cnt got %0d exp 0", cmpl_cnt); end
      areset = 1'b0;
      @(negedge clk);
      vec++; if (sq_ready !== 1'b1) begin err++; $display("FAIL rst_release_sq_ready got %b exp 1", sq_ready); end
      vec++; if (s_axis_tready !== 1'b0) begin err++; $display("FAIL rst_release_tready got %b exp 0", s_axis_tready); end
   endtask

   task automatic test_basic();
      logic [DB-1:0] d;
      send_desc(28'd128, 6'd5);
      vec++; if (s_axis_tready !== 1'b1 || sq_ready !== 1'b0) begin err++;
         $display("FAIL basic_after_hs got tready=%b sq_ready=%b exp 1/0", s_axis_tready, sq_ready); end
      d = '0; d[31:0] = 32'h1111_1111;
      send_beat(d, '1, 1'b0);
      vec++; if (cq_valid !== 1'b0) begin err++; $display("FAIL basic_mid_cq_valid got %b exp 0", cq_valid); end
      d = '0; d[31:0] = 32'h2222_2222;
      send_beat(d, '1, 1'b1);
      vec++; if (cq_valid !== 1'b1) begin err++; $display("FAIL basic_cq_valid got %b exp 1", cq_valid); end
      vec++; if (cq_status !== 2'b00) begin err++; $display("FAIL basic_status got %b exp 00", cq_status); end
      vec++; if (cq_bytes !== 28'd128) begin err++; $display("FAIL basic_bytes got %0d exp 128", cq_bytes); end
      vec++; if (cq_tid !== 6'd5) begin err++; $display("FAIL basic_tid got %0d exp 5", cq_tid); end
      vec++; if (cq_csum !== 32'h3333_3333) begin err++; $display("FAIL basic_csum got %h exp 33333333", cq_csum); end
      retire(); exp_cnt++;
      vec++; if (cmpl_cnt !== exp_cnt) begin err++; $display("FAIL basic_cmpl_cnt got %0d exp %0d", cmpl_cnt, exp_cnt); end
      vec++; if (sq_ready !== 1'b1 || cq_valid !== 1'b0) begin err++;
         $display("FAIL basic_after_cq got sq_ready=%b cq_valid=%b exp 1/0", sq_ready, cq_valid); end
   endtask

   task automatic test_keep();
      logic [KB-1:0] k2  [3] = '{64'h0000_000F_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'h0000_0003_FFFF_FFFF};
      logic [1:0]    st  [3] = '{2'b00, 2'b11, 2'b11};
      logic [LB-1:0] by  [3] = '{28'd100, 28'd96, 28'd98};
      logic [31:0]   cs  [3] = '{32'hABB9_CFD9, 32'h0102_0304, 32'h0102_CFD9};
      logic [DB-1:0] d;
      for (int i = 0; i < 3; i++) begin
         send_desc(28'd100, TB'(7 + i));
         d = '0; d[31:0] = 32'h0102_0304;
         send_beat(d, '1, 1'b0);
         d = '0; d[287:256] = 32'hAABB_CCDD; d[319:288] = 32'hDEAD_BEEF;
         send_beat(d, k2[i], 1'b1);
         vec++; if (cq_valid !== 1'b1) begin err++; $display("FAIL keep%0d_cq_valid got %b exp 1", i, cq_valid); end
         vec++; if (cq_status !== st[i]) begin err++; $display("FAIL keep%0d_status got %b exp %b", i, cq_status, st[i]); end
         vec++; if (cq_bytes !== by[i]) begin err++; $display("FAIL keep%0d_bytes got %0d exp %0d", i, cq_bytes, by[i]); end
         vec++; if (cq_csum !== cs[i]) begin err++; $display("FAIL keep%0d_csum got %h exp %h", i, cq_csum, cs[i]); end
         retire(); exp_cnt++;
         vec++; if (cmpl_cnt !== exp_cnt) begin err++; $display("FAIL keep%0d_cmpl_cnt got %0d exp %0d", i, cmpl_cnt, exp_cnt); end
      end
   endtask

   task automatic test_early_last();
      logic [DB-1:0] d;
      send_desc(28'd192, 6'd12);
      d = '0; d[31:0] = 32'h0000_AAAA;
      send_beat(d, '1, 1'b0);
      d = '0; d[31:0] = 32'h0000_5555;
      send_beat(d, '1, 1'b1);
      vec++; if (cq_valid !== 1'b1) begin err++; $display("FAIL early_cq_valid got %b exp 1", cq_valid); end
      vec++; if (cq_status !== 2'b01) begin err++; $display("FAIL early_status got %b exp 01", cq_status); end
      vec++; if (cq_csum !== 32'h0000_FFFF) begin err++; $display("FAIL early_csum got %h exp 0000ffff", cq_csum); end
      s_axis_tvalid = 1'b1; s_axis_tdata = '1; s_axis_tkeep = '1; s_axis_tlast = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vec++; if (s_axis_tready !== 1'b0) begin err++; $display("FAIL early_no_third_tready got %b exp 0", s_axis_tready); end
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      vec++; if (cq_bytes !== 28'd128) begin err++; $display("FAIL early_bytes got %0d exp 128", cq_bytes); end
      retire(); exp_cnt++;
      vec++; if (cmpl_cnt !== exp_cnt) begin err++; $display("FAIL early_cmpl_cnt got %0d exp %0d", cmpl_cnt, exp_cnt); end
   endtask

   task automatic test_no_last();
      logic [DB-1:0] d;
      send_desc(28'd64, 6'd33);
      d = '0; d[31:0] = 32'hCAFE_F00D;
      send_beat(d, '1, 1'b0);
      vec++; if (cq_valid !== 1'b0 || s_axis_tready !== 1'b1) begin err++;
         $display("FAIL nolast_drain got cq_valid=%b tready=%b exp 0/1", cq_valid, s_axis_tready); end
      vec++; if (cq_status !== 2'b10) begin err++; $display("FAIL nolast_drain_status got %b exp 10", cq_status); end
      for (int i = 0; i < 2; i++) begin
         send_beat('1, '1, 1'b0);
         vec++; if (cq_valid !== 1'b0) begin err++; $display("FAIL nolast_drain%0d_cq_valid got %b exp 0", i, cq_valid); end
      end
      send_beat('1, '1, 1'b1);
      vec++; if (cq_valid !== 1'b1) begin err++; $display("FAIL nolast_cq_valid got %b exp 1", cq_valid); end
      vec++; if (cq_status !== 2'b10) begin err++; $display("FAIL nolast_status got %b exp 10", cq_status); end
      vec++; if (cq_bytes !== 28'd64) begin err++; $display("FAIL nolast_bytes got %0d exp 64", cq_bytes); end
      vec++; if (cq_csum !== 32'hCAFE_F00D) begin err++; $display("FAIL nolast_csum got %h exp cafef00d", cq_csum); end
      retire(); exp_cnt++;
      vec++; if (cmpl_cnt !== exp_cnt) begin err++; $display("FAIL nolast_cmpl_cnt got %0d exp %0d", cmpl_cnt, exp_cnt); end
   endtask

   task automatic test_zero_len();
      vec++; if (cq_valid !== 1'b0) begin err++; $display("FAIL zero_pre_cq_valid got %b exp 0", cq_valid); end
      send_desc(28'd0, 6'd9);
      vec++; if (cq_valid !== 1'b1) begin err++; $display("FAIL zero_cq_valid got %b exp 1", cq_valid); end
      vec++; if (cq_status !== 2'b00 || cq_bytes !== 28'd0 || cq_csum !== 32'd0) begin err++;
         $display("FAIL zero_fields got st=%b bytes=%0d csum=%h exp 00/0/0", cq_status, cq_bytes, cq_csum); end
      s_axis_tvalid = 1'b1; s_axis_tkeep = '1; s_axis_tdata = '1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vec++; if (cq_valid !== 1'b1 || cq_tid !== 6'd9 || cq_bytes !== 28'd0 || cq_status !== 2'b00) begin err++;
            $display("FAIL zero_hold%0d got valid=%b tid=%0d bytes=%0d st=%b exp 1/9/0/00", i, cq_valid, cq_tid, cq_bytes, cq_status); end
         vec++; if (sq_ready !== 1'b0 || s_axis_tready !== 1'b0) begin err++;
            $display("FAIL zero_hold%0d_ready got sq_ready=%b tready=%b exp 0/0", i, sq_ready, s_axis_tready); end
      end
      s_axis_tvalid = 1'b0;
      retire(); exp_cnt++;
      vec++; if (cmpl_cnt !== exp_cnt || sq_ready !== 1'b1) begin err++;
         $display("FAIL zero_retire got cnt=%0d sq_ready=%b exp %0d/1", cmpl_cnt, sq_ready, exp_cnt); end
   endtask

   task automatic test_saturation();
      int unsigned n = 0;
      s8_sq_valid = 1'b1; s8_sq_len = 8'd255; s8_sq_tid = 6'd2;
      while (!s8_sq_ready && n < 20) begin @(negedge clk); n++; end
      vec++; if (s8_sq_ready !== 1'b1) begin err++; $display("FAIL sat_sq_ready got %b exp 1", s8_sq_ready); end
      @(negedge clk);
      s8_sq_valid = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         s8_tvalid = 1'b1; s8_tkeep = '1; s8_tdata = '0; s8_tdata[31:0] = 32'(b); s8_tlast = (b == 4);
         n = 0;
         while (!s8_tready && n < 20) begin @(negedge clk); n++; end
         vec++; if (s8_tready !== 1'b1) begin err++; $display("FAIL sat_beat%0d_tready got %b exp 1", b, s8_tready); end
         @(negedge clk);
      end
      s8_tvalid = 1'b0; s8_tlast = 1'b0;
      vec++; if (s8_cq_valid !== 1'b1) begin err++; $display("FAIL sat_cq_valid got %b exp 1", s8_cq_valid); end
      vec++; if (s8_cq_bytes !== 8'd255) begin err++; $display("FAIL sat_bytes got %0d exp 255", s8_cq_bytes); end
      vec++; if (s8_cq_status !== 2'b11) begin err++; $display("FAIL sat_status got %b exp 11", s8_cq_status); end
      vec++; if (s8_cq_csum !== 32'd4 || s8_cq_tid !== 6'd2) begin err++;
         $display("FAIL sat_csum_tid got csum=%h tid=%0d exp 00000004/2", s8_cq_csum, s8_cq_tid); end
      s8_cq_ready = 1'b1;
      @(negedge clk);
      s8_cq_ready = 1'b0;
      vec++; if (s8_cmpl_cnt !== 32'd1) begin err++; $display("FAIL sat_cmpl_cnt got %0d exp 1", s8_cmpl_cnt); end
   endtask

   task automatic test_reset_mid();
      send_desc(28'd256, 6'd21);
      send_beat('1, '1, 1'b0);
      areset = 1'b1;
      @(negedge clk);
      areset = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tkeep = '1; s_axis_tlast = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++; if (s_axis_tready !== 1'b0 || cq_valid !== 1'b0) begin err++;
            $display("FAIL rmid%0d got tready=%b cq_valid=%b exp 0/0", i, s_axis_tready, cq_valid); end
         vec++; if (cmpl_cnt !== 32'd0 || sq_ready !== 1'b1) begin err++;
            $display("FAIL rmid%0d_cnt got cnt=%0d sq_ready=%b exp 0/1", i, cmpl_cnt, sq_ready); end
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      exp_cnt = 0;
      send_desc(28'd64, 6'd1);
      send_beat('1, '1, 1'b1);
      vec++; if (cq_valid !== 1'b1 || cq_status !== 2'b00 || cq_bytes !== 28'd64 || cq_tid !== 6'd1) begin err++;
         $display("FAIL rmid_new got valid=%b st=%b bytes=%0d tid=%0d exp 1/00/64/1", cq_valid, cq_status, cq_bytes, cq_tid); end
      retire(); exp_cnt++;
      vec++; if (cmpl_cnt !== exp_cnt) begin err++; $display("FAIL rmid_cmpl_cnt got %0d exp %0d", cmpl_cnt, exp_cnt); end
   endtask

   initial begin
      areset = 1'b1;
      sq_valid = 1'b0; sq_len = '0; sq_tid = '0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
      cq_ready = 1'b0;
      s8_sq_valid = 1'b0; s8_sq_len = '0; s8_sq_tid = '0;
      s8_tvalid = 1'b0; s8_tdata = '0; s8_tkeep = '0; s8_tlast = 1'b0;
      s8_cq_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_keep();
      test_early_last();
      test_no_last();
      test_zero_len();
      test_saturation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec, err);
      $fatal(1);
   end

endmodule
